// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - valid/ready result channel from a producer into the writeback FIFO
//
// One producer-to-writeback result channel.
//   valid  producer -> writeback  result present this cycle
//   ready  writeback -> producer  result accepted when valid & ready
//   addr   producer -> writeback  destination register (5 bits)
//   data   producer -> writeback  result value (32 bits)
interface regfile_writeback_if;
  logic        valid;
  logic        ready;
  logic [4:0]  addr;
  logic [31:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-producer write buffer draining into the register file write port
//
// Accepts results from the MEM path and the ALU path (MEM has fixed priority),
// queues them in a DEPTH-entry FIFO and retires one entry per cycle onto the
// register file write port. Also reports whether a decode read address still
// has a write pending in the FIFO or the writeback stage.
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem, alu                    producer channels (valid/ready/addr/data)
//   wb_addr, wb_data, wb_we     register file write port
//   chk_addr_one/two            decode read addresses to check
//   chk_busy_one/two            a write to that address is still in flight
//   fifo_count                  occupied FIFO entries
module regfile_writeback #(
  parameter int DEPTH    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_writeback_if.slave         mem,
  regfile_writeback_if.slave         alu,
  output logic [4:0]                 wb_addr,
  output logic [31:0]                wb_data,
  output logic                       wb_we,
  input  logic [4:0]                 chk_addr_one,
  input  logic [4:0]                 chk_addr_two,
  output logic                       chk_busy_one,
  output logic                       chk_busy_two,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          not_full;
  logic          mem_fire;
  logic          alu_fire;
  logic [4:0]    in_addr;
  logic [31:0]   in_data;
  logic          drop_zero;
  logic          push;
  logic          pop;
  logic [DEPTH-1:0] entry_valid;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never opens a slot combinationally.
  assign not_full  = (count != CW'(DEPTH));
  assign mem.ready = rst_n & not_full;
  assign alu.ready = rst_n & not_full & ~mem.valid;

  assign mem_fire  = mem.valid & mem.ready;
  assign alu_fire  = alu.valid & alu.ready;
  assign in_addr   = mem_fire ? mem.addr : alu.addr;
  assign in_data   = mem_fire ? mem.data : alu.data;

  // Writes to r0 complete the handshake but are never queued.
  assign drop_zero = ZERO_REG && (in_addr == 5'd0);
  assign push      = (mem_fire | alu_fire) & ~drop_zero;
  assign pop       = (count != '0);

  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wb_addr <= fifo_addr[rd_ptr];
        wb_data <= fifo_data[rd_ptr];
        wb_we   <= 1'b1;
      end else begin
        wb_we   <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= in_addr;
      fifo_data[wr_ptr] <= in_data;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = (CW'(PW'(i) - rd_ptr) < count);
    end
  end

  always_comb begin
    chk_busy_one = wb_we & (wb_addr == chk_addr_one);
    chk_busy_two = wb_we & (wb_addr == chk_addr_two);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && fifo_addr[i] == chk_addr_one) chk_busy_one = 1'b1;
      if (entry_valid[i] && fifo_addr[i] == chk_addr_two) chk_busy_two = 1'b1;
    end
    if (ZERO_REG && chk_addr_one == 5'd0) chk_busy_one = 1'b0;
    if (ZERO_REG && chk_addr_two == 5'd0) chk_busy_two = 1'b0;
  end

endmodule
